// File: rtl/watch_disp_scan.sv
// Six-digit multiplexed 7-segment driver for the stopwatch display buffer.
// A frame snapshots the inputs, then scans digit5..digit0 with dwell/blank slots.
module watch_disp_scan #(
    parameter int DWELL_CYC    = 2,
    parameter int BLANK_CYC    = 1,
    parameter int BLINK_FRAMES = 25
) (
    input  logic        clk_1Khz,
    input  logic        rst_n,
    input  logic [23:0] dispbuf,
    input  logic        lz_en,
    input  logic [5:0]  blink_en,
    input  logic [5:0]  dp_mask,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = (DWELL_CYC + BLANK_CYC + 1 > 2) ? $clog2(DWELL_CYC + BLANK_CYC + 1) : 1;
    localparam int FW = (BLINK_FRAMES + 1 > 2) ? $clog2(BLINK_FRAMES + 1) : 1;

    typedef enum logic [1:0] {LOAD, ACTIVE, BLANK} state_t;

    state_t          state, state_n;
    logic [2:0]      idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [FW-1:0]   frame_cnt, frame_cnt_n;
    logic            blink_off, blink_off_n;
    logic [23:0]     snap_buf, snap_buf_n;
    logic            snap_lz, snap_lz_n;
    logic [5:0]      snap_blink, snap_blink_n;
    logic [5:0]      snap_dp, snap_dp_n;
    logic            snap_phase, snap_phase_n;
    logic [5:0]      an_n;
    logic [6:0]      seg_n;
    logic            dp_n;
    logic            fs_n;
    logic [5:0]      supp;
    logic            zero_run;
    logic [3:0]      nib;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        frame_cnt_n  = frame_cnt;
        blink_off_n  = blink_off;
        snap_buf_n   = snap_buf;
        snap_lz_n    = snap_lz;
        snap_blink_n = snap_blink;
        snap_dp_n    = snap_dp;
        snap_phase_n = snap_phase;
        case (state)
            LOAD: begin
                state_n      = ACTIVE;
                idx_n        = 3'd5;
                cnt_n        = '0;
                snap_buf_n   = dispbuf;
                snap_lz_n    = lz_en;
                snap_blink_n = blink_en;
                snap_dp_n    = dp_mask;
                // The frame about to start uses the blink phase in force before this toggle.
                snap_phase_n = blink_off;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_n = '0;
                    blink_off_n = ~blink_off;
                end else begin
                    frame_cnt_n = frame_cnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt == CW'(DWELL_CYC - 1)) begin
                    cnt_n = '0;
                    if (BLANK_CYC > 0)    state_n = BLANK;
                    else if (idx == 3'd0) state_n = LOAD;
                    else                  idx_n   = idx - 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    cnt_n = '0;
                    if (idx == 3'd0) state_n = LOAD;
                    else begin
                        state_n = ACTIVE;
                        idx_n   = idx - 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = LOAD;
        endcase

        // Suppress a digit while it and everything above it is zero with no dp lit.
        zero_run = 1'b1;
        supp     = '0;
        for (int k = 5; k >= 1; k--) begin
            zero_run = zero_run && (snap_buf_n[4*k +: 4] == 4'd0) && !snap_dp_n[k];
            supp[k]  = snap_lz_n && zero_run;
        end

        nib   = snap_buf_n[{idx_n, 2'b00} +: 4];
        an_n  = 6'h3F;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        fs_n  = (state == LOAD);
        if (state_n == ACTIVE && !supp[idx_n] && !(snap_phase_n && snap_blink_n[idx_n])) begin
            an_n  = ~(6'd1 << idx_n);
            seg_n = decode(nib);
            dp_n  = ~snap_dp_n[idx_n];
        end
    end

    always_ff @(posedge clk_1Khz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            idx         <= 3'd5;
            cnt         <= '0;
            frame_cnt   <= '0;
            blink_off   <= 1'b0;
            snap_buf    <= '0;
            snap_lz     <= 1'b0;
            snap_blink  <= '0;
            snap_dp     <= '0;
            snap_phase  <= 1'b0;
            an          <= 6'h3F;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            frame_cnt   <= frame_cnt_n;
            blink_off   <= blink_off_n;
            snap_buf    <= snap_buf_n;
            snap_lz     <= snap_lz_n;
            snap_blink  <= snap_blink_n;
            snap_dp     <= snap_dp_n;
            snap_phase  <= snap_phase_n;
            an          <= an_n;
            seg         <= seg_n;
            dp          <= dp_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_watch_disp_scan.sv
// Directed bench for watch_disp_scan: checks full frame timelines, suppression,
// snapshotting, blink phases and asynchronous reset against hand-derived tables.
module tb_watch_disp_scan;

    logic        clk_1Khz = 1'b0;
    logic        rst_n;
    logic [23:0] dispbuf;
    logic        lz_en;
    logic [5:0]  blink_en;
    logic [5:0]  dp_mask;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] OFF = {1'b0, 6'h3F, 7'h7F, 1'b1};

    watch_disp_scan #(.DWELL_CYC(2), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
        .clk_1Khz    (clk_1Khz),
        .rst_n       (rst_n),
        .dispbuf     (dispbuf),
        .lz_en       (lz_en),
        .blink_en    (blink_en),
        .dp_mask     (dp_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    function automatic logic [14:0] obs();
        return {frame_start, an, seg, dp};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {fs,an,seg,dp}=%h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge of cycle 1 of a frame; returns at cycle 1 of the next frame.
    // segs holds digit5 in the top 7 bits; dispbuf is overwritten at cycle chg_cyc if nonzero.
    task automatic check_frame(input string name, input logic [41:0] segs, input logic [5:0] lit,
                               input logic [5:0] dps, input int chg_cyc, input logic [23:0] chg_val);
        int          c;
        logic [14:0] e;
        logic [5:0]  an_e;
        c = 1;
        for (int k = 5; k >= 0; k--) begin
            for (int d = 0; d < 2; d++) begin
                an_e = ~(6'd1 << k);
                if (lit[k]) e = {(k == 5 && d == 0), an_e, segs[7*k +: 7], ~dps[k]};
                else        e = {(k == 5 && d == 0), 6'h3F, 7'h7F, 1'b1};
                check($sformatf("%s d%0d c%0d", name, k, c), obs(), e);
                if (c == chg_cyc) dispbuf = chg_val;
                @(negedge clk_1Khz); c++;
            end
            check($sformatf("%s blank%0d c%0d", name, k, c), obs(), OFF);
            if (c == chg_cyc) dispbuf = chg_val;
            @(negedge clk_1Khz); c++;
        end
        check($sformatf("%s load c%0d", name, c), obs(), OFF);
        @(negedge clk_1Khz);
    endtask

    initial begin
        rst_n    = 1'b0;
        dispbuf  = 24'h012345;
        lz_en    = 1'b0;
        blink_en = 6'b000000;
        dp_mask  = 6'b000000;
        repeat (3) @(negedge clk_1Khz);
        check("reset_hold", obs(), OFF);
        rst_n = 1'b1;
        #1 check("cycle0_load", obs(), OFF);
        @(negedge clk_1Khz);

        dispbuf = 24'h000705; lz_en = 1'b1;
        check_frame("f0_012345", {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 6'b111111, 6'b0, 0, 24'h0);

        dispbuf = 24'h000000;
        check_frame("f1_lz705", {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h12}, 6'b000111, 6'b0, 0, 24'h0);

        dp_mask = 6'b010000;
        check_frame("f2_lz0", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 6'b000001, 6'b0, 0, 24'h0);

        dispbuf = 24'hF0000A; dp_mask = 6'b000000;
        check_frame("f3_lzdp", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b011111, 6'b010000, 0, 24'h0);

        dispbuf = 24'h111111; lz_en = 1'b0;
        check_frame("f4_hex", {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 6'b111111, 6'b0, 0, 24'h0);

        check_frame("f5_snap1", {6{7'h79}}, 6'b111111, 6'b0, 8, 24'h222222);
        check_frame("f6_snap2", {6{7'h24}}, 6'b111111, 6'b0, 0, 24'h0);

        // Walk into the digit2 slot of the next frame, then assert reset there.
        repeat (9) @(negedge clk_1Khz);
        check("pre_reset_d2", obs(), {1'b0, 6'b111011, 7'h24, 1'b1});
        rst_n = 1'b0;
        #1 check("async_reset", obs(), OFF);
        blink_en = 6'b000001;
        repeat (3) @(negedge clk_1Khz);
        check("reset_hold2", obs(), OFF);
        rst_n = 1'b1;
        #1 check("cycle0_load2", obs(), OFF);
        @(negedge clk_1Khz);

        for (int n = 0; n < 6; n++) begin
            check_frame($sformatf("blink_f%0d", n), {6{7'h24}},
                        {5'b11111, ((n >> 1) & 1) == 0}, 6'b0, 0, 24'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
